// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg: size encodings, FSM states and helpers for mem_stage_lsu    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_e;

  // Encoding 2'b11 behaves as a word everywhere.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lsb[0];
      default: return |lsb;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_extend: zero/sign extension of an assembled load value           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        se,
  input  logic [31:0] raw,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = raw;
    case (size)
      SZ_BYTE: rdata = {{24{se & raw[7]}}, raw[7:0]};
      SZ_HALF: rdata = {{16{se & raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_lsu: byte-serial big-endian load/store sequencer (MEM)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              se,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       acc_q, acc_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              se_q, se_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [1:0]  last_idx;
  logic [1:0]  wr_sel;
  logic [31:0] raw_load;
  logic [31:0] ext_load;

  generate
    if (ADDR_W < 32) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[31:ADDR_W];
    end
  endgenerate

  assign last_idx = 2'(size_bytes(size_q) - 3'd1);
  // Big-endian store: first byte out is the most significant of the N-byte quantity.
  assign wr_sel   = last_idx - idx_q;
  assign raw_load = {acc_q, mem_rdata};

  lsu_extend u_extend (
    .size  (size_q),
    .se    (se_q),
    .raw   (raw_load),
    .rdata (ext_load)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    rw_d    = rw_q;
    size_d  = size_q;
    se_d    = se_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rw_d    = rw;
          size_d  = size;
          se_d    = se;
          addr_d  = addr[ADDR_W-1:0];
          wdata_d = wdata;
          idx_d   = 2'd0;
          acc_d   = 24'd0;
          if (is_misaligned(size, addr[1:0])) begin
            state_d = DONE;
            rdata_d = 32'd0;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        idx_d = idx_q + 2'd1;
        if (!rw_q) acc_d = raw_load[23:0];
        if (idx_q == last_idx) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!rw_q) rdata_d = ext_load;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      acc_q   <= 24'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rw_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      se_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      se_q    <= se_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Stall is combinational from start so the hazard unit freezes in the arrival cycle.
  assign busy       = ((state_q == IDLE) && start) || (state_q == ACCESS);
  assign done       = done_q;
  assign misaligned = mis_q;
  assign rdata      = rdata_q;
  assign mem_en     = (state_q == ACCESS);
  assign mem_we     = (state_q == ACCESS) && rw_q;
  assign mem_addr   = (state_q == ACCESS) ? addr_q + ADDR_W'(idx_q) : '0;
  assign mem_wdata  = mem_we ? wdata_q[{wr_sel, 3'b000} +: 8] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage_lsu: table-driven self-checking bench for mem_stage_lsu |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_stage_lsu;

  logic        Clk = 1'b0;
  logic        R = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        se = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, misaligned, mem_en, mem_we;
  logic [31:0] rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem [0:255];
  logic [15:0] wlog [$];

  int total = 0;
  int passed = 0;

  always #5 Clk = ~Clk;

  mem_stage_lsu #(.ADDR_W(8)) dut (
    .Clk(Clk), .R(R), .start(start), .rw(rw), .size(size), .se(se),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
  end

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        se;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    logic [31:0] exp_bytes;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Presents one op, holds start through DONE, drops it in the following cycle.
  task automatic do_op(input logic op_rw, input logic [1:0] op_size, input logic op_se,
                       input logic [31:0] op_addr, input logic [31:0] op_wdata,
                       output int lat, output int busy_cnt, output int en_cnt,
                       output int done_cnt, output logic mis_at, output logic [31:0] rd_at);
    lat = 0; busy_cnt = 0; en_cnt = 0; done_cnt = 0; mis_at = 1'b0; rd_at = 32'd0;
    start = 1'b1; rw = op_rw; size = op_size; se = op_se; addr = op_addr; wdata = op_wdata;
    for (int cyc = 0; cyc < 12 && lat == 0; cyc++) begin
      #1;
      if (busy) busy_cnt++;
      if (mem_en) en_cnt++;
      if (done) begin
        done_cnt++;
        lat = cyc;
        mis_at = misaligned;
        rd_at = rdata;
      end
      @(posedge Clk);
      #2;
    end
    start = 1'b0; rw = 1'b0; size = 2'b00; se = 1'b0; addr = 32'd0; wdata = 32'd0;
    #1;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  int          lat, bcnt, ecnt, dcnt;
  logic        mis_at;
  logic [31:0] rd_at;
  logic [31:0] eb;
  int          n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h80;
    mem[8'h20] = 8'h85; mem[8'h21] = 8'h34;
    mem[8'h30] = 8'h12; mem[8'h31] = 8'h34; mem[8'h32] = 8'h56; mem[8'h33] = 8'h78;
    mem[8'hFF] = 8'h7F;
    mem[8'h72] = 8'hAA; mem[8'h73] = 8'hAA;

    //          rw    size   se    addr          wdata         exp_rdata     mis  lat exp_bytes
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 5, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h40,       32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h40,       32'h0,        32'h00000080, 1'b0, 2, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h20,       32'h0,        32'hFFFF8534, 1'b0, 3, 32'h0};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        32'h00008534, 1'b0, 3, 32'h0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h30,       32'h0,        32'h12345678, 1'b0, 5, 32'h0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h13,       32'h0,        32'h00000000, 1'b1, 1, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h21,       32'h0,        32'h00000000, 1'b1, 1, 32'h0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'hFF,       32'h0,        32'h0000007F, 1'b0, 2, 32'h0};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h60,       32'hAABBCCA5, 32'h0,        1'b0, 2, 32'h000000A5};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h62,       32'h12349876, 32'h0,        1'b0, 3, 32'h00009876};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 5, 32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h12345630, 32'h0,        32'h12345678, 1'b0, 5, 32'h0};

    // Reset values
    #12;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst misaligned", {31'd0, misaligned}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst mem_bus", {14'd0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
    @(negedge Clk);
    R = 1'b1;
    @(posedge Clk);
    #2;

    // Ops are presented back-to-back: each starts in the cycle after the previous DONE.
    for (int i = 0; i < 13; i++) begin
      wlog.delete();
      do_op(vecs[i].rw, vecs[i].size, vecs[i].se, vecs[i].addr, vecs[i].wdata,
            lat, bcnt, ecnt, dcnt, mis_at, rd_at);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d busy_cycles", i), bcnt, vecs[i].exp_lat);
      check($sformatf("v%0d mem_en_cycles", i), ecnt, vecs[i].exp_lat - 1);
      check($sformatf("v%0d done_pulses", i), dcnt, 1);
      check($sformatf("v%0d misaligned", i), {31'd0, mis_at}, {31'd0, vecs[i].exp_mis});
      if (!vecs[i].rw) begin
        check($sformatf("v%0d rdata", i), rd_at, vecs[i].exp_rdata);
        check($sformatf("v%0d rdata_held", i), rdata, vecs[i].exp_rdata);
      end else begin
        n = vecs[i].exp_lat - 1;
        eb = vecs[i].exp_bytes;
        check($sformatf("v%0d write_count", i), wlog.size(), n);
        for (int k = 0; k < n && k < wlog.size(); k++)
          check($sformatf("v%0d write%0d", i, k), {16'd0, wlog[k]},
                {16'd0, vecs[i].addr[7:0] + 8'(k), eb[8*(n-1-k) +: 8]});
      end
    end

    // Reset during a word store, just after the edge that wrote addr+1
    wlog.delete();
    start = 1'b1; rw = 1'b1; size = 2'b10; se = 1'b0; addr = 32'h70; wdata = 32'h11223344;
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    check("c2 mem_addr", {24'd0, mem_addr}, 32'h71);
    @(posedge Clk); #1;
    R = 1'b0; start = 1'b0; rw = 1'b0; size = 2'b00; addr = 32'd0; wdata = 32'd0;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk); #2;
      check("midrst no_done", {31'd0, done}, 32'd0);
    end
    check("midrst mem70", {24'd0, mem[8'h70]}, 32'h11);
    check("midrst mem71", {24'd0, mem[8'h71]}, 32'h22);
    check("midrst mem72", {24'd0, mem[8'h72]}, 32'hAA);
    check("midrst mem73", {24'd0, mem[8'h73]}, 32'hAA);
    @(negedge Clk);
    R = 1'b1;
    @(posedge Clk); #2;
    do_op(1'b0, 2'b00, 1'b0, 32'h71, 32'h0, lat, bcnt, ecnt, dcnt, mis_at, rd_at);
    check("post_rst latency", lat, 2);
    check("post_rst rdata", rd_at, 32'h00000022);
    check("post_rst done_pulses", dcnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
